y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares the single-ported y86 memory bus between two masters: M0 (CPU fetch/load/store port) and M1 (DMA/debug loader).
- Masters use a req/ack handshake; the block arbitrates, latches the winner's command, drives the memory bus for one cycle, captures read data and returns ack.
- Sits between the CPU core, the DMA/debug master and the memory model.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  M0 access request; held until m0_ack.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_rdata  out  DW  M0 read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the M0 set, for M1.
- mem_A  out  AW  memory address.
- mem_RE  out  1  memory read strobe.
- mem_WE  out  1  memory write strobe.
- mem_out  out  DW  memory write data.
- mem_in  in  DW  memory read data; valid the cycle after mem_RE.
- busy  out  1  high in ACCESS or RESP.
- gnt_id  out  1  master owning the current access; 0 when idle.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - If any req is high, pick a winner and latch its id, we, addr and wdata at the edge; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle)
  - mem_A = latched addr.
  - mem_RE = !we; mem_WE = we; mem_out = latched wdata.
  - Go to RESP.
- RESP (exactly 1 cycle)
  - mem_A, mem_RE, mem_WE low/zero.
  - Read: register mem_in into rdata at the edge ending ACCESS.
  - Assert ack of the granted master only; rdata is valid.
  - Writes also ack; rdata holds its previous value.
  - Go to IDLE.
- Latency: req seen in IDLE at cycle t -> memory strobe at t+1 -> ack at t+2. Peak throughput is 1 access per 3 cycles.
- Arbitration: 2-way round robin.
  - last_gnt register, reset value 1, so M0 wins the first tie.
  - On a tie, the master not granted last wins.
  - Single requester wins immediately.
  - last_gnt updates only when a grant is taken.
- Command latching: addr, we and wdata are latched at the grant edge. Changes on the master side after the grant are ignored.
- Master rules:
  - A master keeps req high until its ack.
  - Dropping req before it is granted withdraws the request without side effects.
  - req still high in the IDLE cycle after ack counts as a new request.
- Non-granted master: its req stays pending. Its ack and rdata are unaffected (ack=0).
- Reset values: state=IDLE, last_gnt=1, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, mem_A=0, mem_RE=mem_WE=0, mem_out=0, busy=0, gnt_id=0.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. A write strobe already driven in ACCESS is not retracted; the memory sees it.
- Both ack outputs are never high in the same cycle. mem_RE and mem_WE are never both high.

Optional Feature:
- Macro: Y86_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. M0 always wins a tie and last_gnt is unused; M1 can starve while M0 requests back-to-back.
- Undefined: round robin as above.

Decomposition:
- Package y86_bus_pkg:
  - arb_state_t enum (IDLE, ACCESS, RESP).
  - master_id_t (1 bit), with constants M_CPU=0 and M_DMA=1.
  - Default AW/DW localparams.
- Sub-module y86_rr_arb2: combinational 2-way picker.
  - Inputs: req[1:0], last_gnt, fixed_prio.
  - Outputs: gnt_valid, gnt_id.
  - Reused by later bus masters.

Test Plan:
- M0 read only: m0_req=1, addr=0x10, memory returns 0xDEADBEEF -> mem_RE high 1 cycle later, m0_ack plus m0_rdata=0xDEADBEEF 2 cycles later, m1_ack stays 0.
- M1 write: m1_req=1, we=1, addr=0x20, wdata=0x12345678 -> mem_WE for 1 cycle with mem_A=0x20 and mem_out=0x12345678, then m1_ack.
- Both masters request continuously from reset -> grants go M0, M1, M0, M1; ack every 3 cycles.
  - With Y86_ARB_FIXED_PRIO_EN defined: all grants go to M0.
- Master changes addr 0x30->0x40 the cycle after its grant -> mem_A=0x30.
  - M1 drops req before being granted -> no M1 access issued.
- rst asserted during ACCESS of an M0 read -> next cycle state IDLE, no m0_ack, all outputs at reset values, last_gnt=1.

Source files
------------

// File: rtl/y86_bus_pkg.sv
// y86 memory bus package: shared state, master-id types and default widths
// for the blocks that sit on the y86 memory bus.
package y86_bus_pkg;

    // Default bus widths; blocks expose these as overridable parameters.
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Arbiter transaction phases: wait for a request, drive the bus, answer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // One bit is enough to name either bus master.
    typedef logic master_id_t;

    localparam master_id_t M_CPU = 1'b0;
    localparam master_id_t M_DMA = 1'b1;

    // The master that is not the given one (round-robin partner).
    function automatic master_id_t other_master(input master_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/y86_rr_arb2.sv
// y86_rr_arb2: combinational 2-way request picker.
// A lone requester wins outright. On a tie the winner is M0 when fixed_prio
// is set, otherwise the master that was not granted last (round robin).
// Holds no state: the caller owns last_gnt and decides when a grant is taken.
module y86_rr_arb2
    import y86_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       fixed_prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Choose the winner from the current request pattern.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no path can leave it holding its old value and infer a latch.
        gnt_valid = |req;
        gnt_id    = M_CPU;
        case (req)
            2'b01:   gnt_id = M_CPU;
            2'b10:   gnt_id = M_DMA;
            2'b11:   gnt_id = fixed_prio ? M_CPU : other_master(last_gnt);
            default: gnt_id = M_CPU;
        endcase
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: shares the single-ported y86 memory bus between M0 (CPU)
// and M1 (DMA/debug loader). Each access takes three cycles:
//   IDLE   - arbitrate and latch the winner's command at the edge,
//   ACCESS - drive address and one read or write strobe for one cycle,
//   RESP   - pulse the winner's ack; read data was captured entering RESP.
// Build option: define Y86_ARB_FIXED_PRIO_EN for fixed priority (M0 always
// wins a tie, M1 may starve); otherwise ties alternate round robin.
module y86_mem_arbiter
    import y86_bus_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
)
(
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_A,
    output logic          mem_RE,
    output logic          mem_WE,
    output logic [DW-1:0] mem_out,
    input  logic [DW-1:0] mem_in,

    output logic          busy,
    output logic          gnt_id
);

`ifdef Y86_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_t    state;
    arb_state_t    next_state;

    // Round-robin memory: who won the most recent grant.
    master_id_t    last_gnt;

    // Command of the access in flight, frozen at the grant edge.
    master_id_t    cmd_id;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // Per-master read-data holding registers.
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    logic          arb_valid;
    master_id_t    arb_id;
    logic          grant_take;

    y86_rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_gnt   (last_gnt),
        .fixed_prio (FIXED_PRIO),
        .gnt_valid  (arb_valid),
        .gnt_id     (arb_id)
    );

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus bus strobes, acks and status derived from the phase.
    always_comb begin
        next_state = state;
        grant_take = 1'b0;
        mem_A      = '0;
        mem_RE     = 1'b0;
        mem_WE     = 1'b0;
        mem_out    = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        busy       = 1'b0;
        gnt_id     = M_CPU;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_take = 1'b1;
                    next_state = ACCESS;
                end
            end

            ACCESS: begin
                mem_A      = cmd_addr;
                mem_RE     = !cmd_we;
                mem_WE     = cmd_we;
                mem_out    = cmd_wdata;
                busy       = 1'b1;
                gnt_id     = cmd_id;
                next_state = RESP;
            end

            RESP: begin
                m0_ack     = (cmd_id == M_CPU);
                m1_ack     = (cmd_id == M_DMA);
                busy       = 1'b1;
                gnt_id     = cmd_id;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Remember the last winner; only a taken grant moves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= M_DMA;
        end else if (grant_take) begin
            last_gnt <= arb_id;
        end
    end

    // Freeze the winner's command so later master-side changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: the command register has no reset: it is only observed in ACCESS/RESP, and those are only reached through a grant that loads it.
        if (grant_take) begin
            cmd_id <= arb_id;
            if (arb_id == M_DMA) begin
                cmd_we    <= m1_we;
                cmd_addr  <= m1_addr;
                cmd_wdata <= m1_wdata;
            end else begin
                cmd_we    <= m0_we;
                cmd_addr  <= m0_addr;
                cmd_wdata <= m0_wdata;
            end
        end
    end

    // Capture read data into the owning master's register as ACCESS ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else if (state == ACCESS && !cmd_we) begin
            if (cmd_id == M_DMA) begin
                m1_rdata_q <= mem_in;
            end else begin
                m0_rdata_q <= mem_in;
            end
        end
    end

    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

    // Bus sanity: acks and strobes are each mutually exclusive.
    a_ack_excl: assert property (@(posedge clk) disable iff (rst)
        !(m0_ack && m1_ack));
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_RE && mem_WE));

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Self-checking bench for y86_mem_arbiter: directed transactions, a
// transaction-level reference model compared every cycle, and hand-computed
// literal expectations for latency, data and grant order.
module tb_y86_mem_arbiter;
    import y86_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_A;
    logic          mem_RE, mem_WE;
    logic [DW-1:0] mem_out;
    logic [DW-1:0] mem_in;
    logic          busy;
    logic          gnt_id;

    int n_checks = 0;
    int n_errors = 0;

    y86_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .mem_A    (mem_A),
        .mem_RE   (mem_RE),
        .mem_WE   (mem_WE),
        .mem_out  (mem_out),
        .mem_in   (mem_in),
        .busy     (busy),
        .gnt_id   (gnt_id)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: asynchronous read, write mid-cycle.
    logic [DW-1:0] tb_mem [0:255];
    assign mem_in = tb_mem[mem_A[7:0]];
    always @(negedge clk) begin
        if (mem_WE) tb_mem[mem_A[7:0]] = mem_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: an access granted at the end of cycle g strobes
    // the bus in cycle g+1, acks in g+2 and frees the bus from g+3 on.
    // ---------------------------------------------------------------
    int            cyc = 0;
    bit            mdl_ok = 1'b0;
    bit            live = 1'b0;
    int            g_cyc = 0;
    int            t_id = 0;
    bit            t_we = 1'b0;
    logic [31:0]   t_addr = '0;
    logic [31:0]   t_wdata = '0;
    int            last_win = 1;
    logic [31:0]   exp_rd [2];
    logic [31:0]   ref_mem [0:255];

    always @(posedge clk) begin
        if (rst) begin
            mdl_ok    = 1'b1;
            live      = 1'b0;
            last_win  = 1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else if (mdl_ok) begin
            if (live && cyc == g_cyc + 1) begin
                if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
                else      exp_rd[t_id] = ref_mem[t_addr[7:0]];
            end
            if ((!live || cyc >= g_cyc + 3) && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef Y86_ARB_FIXED_PRIO_EN
                    t_id = 0;
`else
                    t_id = 1 - last_win;
`endif
                end else begin
                    t_id = m1_req ? 1 : 0;
                end
                last_win = t_id;
                t_we     = (t_id == 1) ? m1_we    : m0_we;
                t_addr   = (t_id == 1) ? m1_addr  : m0_addr;
                t_wdata  = (t_id == 1) ? m1_wdata : m0_wdata;
                g_cyc    = cyc;
                live     = 1'b1;
            end
        end
        cyc++;
    end

    bit exp_acc, exp_rsp;

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        if (mdl_ok) begin
            exp_acc = live && (cyc == g_cyc + 1);
            exp_rsp = live && (cyc == g_cyc + 2);
            check("cyc_mem_A",    mem_A,    exp_acc ? t_addr : 32'h0);
            check("cyc_mem_RE",   mem_RE,   exp_acc && !t_we);
            check("cyc_mem_WE",   mem_WE,   exp_acc && t_we);
            check("cyc_mem_out",  mem_out,  exp_acc ? t_wdata : 32'h0);
            check("cyc_busy",     busy,     exp_acc || exp_rsp);
            check("cyc_gnt_id",   gnt_id,   (exp_acc || exp_rsp) ? t_id : 0);
            check("cyc_m0_ack",   m0_ack,   exp_rsp && t_id == 0);
            check("cyc_m1_ack",   m1_ack,   exp_rsp && t_id == 1);
            check("cyc_m0_rdata", m0_rdata, exp_rd[0]);
            check("cyc_m1_rdata", m1_rdata, exp_rd[1]);
            check("cyc_ack_excl", m0_ack && m1_ack, 0);
            check("cyc_strobe_excl", mem_RE && mem_WE, 0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_m(input int id, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    int ack_ids[$];
    int ack_cyc[$];
    int exp_order[4];
    int m1_seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 32'hA5A5_0000 | i;
            ref_mem[i] = 32'hA5A5_0000 | i;
        end
        tb_mem[8'h10]  = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;
`ifdef Y86_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        // Reset state
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",     busy,     0);
        check("rst_gnt_id",   gnt_id,   0);
        check("rst_mem_A",    mem_A,    0);
        check("rst_m0_ack",   m0_ack,   0);
        check("rst_m1_rdata", m1_rdata, 0);

        // M0 read of 0x10: strobe one cycle after the request, ack two after
        next_cycle();
        drive_m(0, 1, 0, 32'h10, 0);
        @(negedge clk);
        check("rd_no_strobe_yet", mem_RE, 0);
        @(negedge clk);
        check("rd_RE",   mem_RE, 1);
        check("rd_A",    mem_A,  32'h10);
        check("rd_gnt",  gnt_id, 0);
        @(negedge clk);
        check("rd_ack",    m0_ack,   1);
        check("rd_data",   m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_ack", m1_ack,   0);
        next_cycle();
        drive_m(0, 0, 0, 0, 0);

        // M1 write of 0x12345678 to 0x20, then M0 reads it back
        next_cycle();
        drive_m(1, 1, 1, 32'h20, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        check("wr_WE",  mem_WE,  1);
        check("wr_RE",  mem_RE,  0);
        check("wr_A",   mem_A,   32'h20);
        check("wr_out", mem_out, 32'h1234_5678);
        check("wr_gnt", gnt_id,  1);
        @(negedge clk);
        check("wr_m1_ack",   m1_ack,   1);
        check("wr_m0_ack",   m0_ack,   0);
        check("wr_m1_rdata", m1_rdata, 0);
        next_cycle();
        drive_m(1, 0, 0, 0, 0);
        drive_m(0, 1, 0, 32'h20, 0);
        repeat (3) @(negedge clk);
        check("rb_ack",  m0_ack,   1);
        check("rb_data", m0_rdata, 32'h1234_5678);
        next_cycle();
        drive_m(0, 0, 0, 0, 0);

        // Both masters request continuously from reset
        next_cycle();
        rst = 1'b1;
        drive_m(0, 1, 0, 32'h04, 0);
        drive_m(1, 1, 0, 32'h08, 0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (m0_ack) begin ack_ids.push_back(0); ack_cyc.push_back(i); end
            if (m1_ack) begin ack_ids.push_back(1); ack_cyc.push_back(i); end
        end
        check("rr_ack_count", ack_ids.size(), 4);
        for (int i = 0; i < 4 && i < ack_ids.size(); i++)
            check($sformatf("rr_grant_%0d", i), ack_ids[i], exp_order[i]);
        for (int i = 1; i < ack_cyc.size(); i++)
            check($sformatf("rr_gap_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        next_cycle();
        drive_m(0, 0, 0, 0, 0);
        drive_m(1, 0, 0, 0, 0);
        repeat (4) next_cycle();

        // Address change after grant is ignored; M1 withdraws before grant
        drive_m(0, 1, 0, 32'h30, 0);
        next_cycle();
        m0_addr = 32'h40;
        drive_m(1, 1, 0, 32'h50, 0);
        @(negedge clk);
        check("lat_A",   mem_A,  32'h30);
        check("lat_gnt", gnt_id, 0);
        next_cycle();
        drive_m(1, 0, 0, 0, 0);
        @(negedge clk);
        check("lat_ack",  m0_ack,   1);
        check("lat_data", m0_rdata, 32'hA5A5_0030);
        next_cycle();
        drive_m(0, 0, 0, 0, 0);
        m1_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (m1_ack || busy || mem_A == 32'h50) m1_seen++;
        end
        check("withdraw_no_m1", m1_seen, 0);

        // Reset during the ACCESS cycle of an M0 read
        next_cycle();
        drive_m(0, 1, 0, 32'h10, 0);
        next_cycle();
        rst = 1'b1;
        drive_m(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rstmid_RE_in_access", mem_RE, 1);
        next_cycle();
        rst = 1'b0;
        drive_m(0, 1, 0, 32'h10, 0);
        drive_m(1, 1, 0, 32'h20, 0);
        @(negedge clk);
        check("rstmid_m0_ack",   m0_ack,   0);
        check("rstmid_busy",     busy,     0);
        check("rstmid_gnt",      gnt_id,   0);
        check("rstmid_mem_A",    mem_A,    0);
        check("rstmid_RE",       mem_RE,   0);
        check("rstmid_m0_rdata", m0_rdata, 0);
        check("rstmid_m1_rdata", m1_rdata, 0);
        @(negedge clk);
        check("rstmid_first_gnt", gnt_id, 0);
        check("rstmid_busy2",     busy,   1);
        @(negedge clk);
        check("rstmid_m0_ack2", m0_ack,   1);
        check("rstmid_m0_data", m0_rdata, 32'hDEAD_BEEF);
        next_cycle();
        drive_m(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rstmid_m1_ack",  m1_ack,   1);
        check("rstmid_m1_data", m1_rdata, 32'h1234_5678);
        next_cycle();
        drive_m(1, 0, 0, 0, 0);
        repeat (4) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
